sobel_stream_filter: RTL and testbench
======================================

# sobel_stream_filter

Parametrised streaming Sobel edge detector: next generation of the 4-bit, fixed 5×5 edge filter in the DE2 image pipeline. Adds generic pixel/output width, a runtime-selectable 3×3/5×5 kernel, true |Gx|+|Gy| magnitude, per-mode scaling with saturation, frame-border masking and an output start-of-frame marker. It sits between the grayscale converter and the VGA frame writer. It accepts one pixel per `in_ready` strobe and has no backpressure.

## Interface
- `PIX_W`, 4, input pixel width (unsigned)
- `OUT_W`, 4, output pixel width
- `IMG_W`, 640, frame width in pixels (≥ 8)
- `IMG_H`, 480, frame height in lines (≥ 5)
- `SHIFT5`, 7, magnitude right-shift in 5×5 mode
- `SHIFT3`, 3, magnitude right-shift in 3×3 mode
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `pixel_in`  in  PIX_W  raster-order input pixel
- `in_ready`  in  1  input strobe; `pixel_in` is accepted on each rising edge where it is high
- `mode_sel`  in  1  0 = 5×5 Sobel, 1 = 3×3 Sobel
- `thresh`  in  OUT_W  binarisation threshold; port exists only with `SOBEL_THRESH_EN`
- `pixel_out`  out  OUT_W  edge value for one window centre
- `out_ready`  out  1  `pixel_out` valid strobe, one cycle per output
- `out_sof`  out  1  high together with `out_ready` for centre (row 0, col 0)

## Operation
- Input counters `in_col`/`in_row` wrap at IMG_W/IMG_H and advance only on accepted pixels.
- Four line buffers (IMG_W × PIX_W each) feed a 5×5 shift-register window. Line buffers are not reset and are inferred as RAM.
- Window centre is the raster pixel located 2·IMG_W+2 accepted pixels earlier.
- A `primed` flag is set once 2·IMG_W+2 pixels have been accepted since reset. Before that, accepted pixels produce no output.
- After priming, every accepted pixel yields exactly one output. Centre counters `c_col`/`c_row` track that output's coordinates.
- The tail of a frame (last 2·IMG_W+2 centres) is emitted only as the next frame's pixels arrive.
- `mode_sel` is sampled on the accepted pixel whose centre is (0,0) and held for the whole output frame.
- 5×5 kernel: smoothing S=[1 4 6 4 1], derivative D=[-1 -2 0 2 1].
  - Gx = Σ S[row]·D[col]·p
  - Gy = Σ D[row]·S[col]·p
- 3×3 kernel: applied to the centre 3×3 of the window, with S=[1 2 1] and D=[-1 0 1].
- Arithmetic is signed.
  - Gx/Gy width is PIX_W+7.
  - MAG = |Gx|+|Gy|, width PIX_W+8, unsigned. No overflow is possible.
- Scaling: MAG >> SHIFT5 or MAG >> SHIFT3, saturated to 2^OUT_W−1.
- Border mask: output is forced to 0 when the centre lies within 2 pixels of any frame edge (5×5 mode) or 1 pixel (3×3 mode).

## Timing
- Fixed 5-stage pipeline with a valid bit per stage. There are no stalls, and gaps in `in_ready` pass through as gaps.
  - S1: weighted terms
  - S2: row sums
  - S3: Gx/Gy
  - S4: magnitude
  - S5: scale, saturate, mask; registered outputs
- Latency: for a pixel accepted at edge N, `out_ready`/`pixel_out`/`out_sof` update at edge N+5 and stay valid for one cycle.
- Reset values: `pixel_out`=0, `out_ready`=0, `out_sof`=0. Reset also clears all counters, `primed`, the window and the pipeline valids.
- Reset mid-frame: all in-flight outputs are discarded, and the next accepted pixel is treated as input (0,0).
- A `mode_sel` change mid-frame has no effect until the next centre (0,0).
- Counter wrap: `in_col` wraps to 0 and `in_row` increments on the same edge. `in_row` wraps to 0 at IMG_H−1/IMG_W−1; the centre counters behave identically.

## Configuration
- `SOBEL_THRESH_EN` defined: the `thresh` port exists. `pixel_out` = all-ones if the scaled, saturated value ≥ `thresh`, else 0; masked borders stay 0.
- Not defined: no `thresh` port, and `pixel_out` is the scaled, saturated magnitude.

## Test plan
All scenarios use IMG_W=8, IMG_H=6, PIX_W=4, OUT_W=4 unless stated.

- Flat frame, all pixels 7, 5×5 mode, continuous `in_ready` → no output for the first 18 inputs. The remaining 30 outputs of frame 1 are all 0.
- Vertical step, cols 0–3 = 0, cols 4–7 = 15, 5×5 mode, SHIFT5=7, rows 2–3 → outputs by centre col 2/3/4/5 are 1/5/5/1; cols 0, 1, 6, 7 and rows 0, 1, 4, 5 are 0.
- Same step, 3×3 mode, SHIFT3=3 → centre cols 3 and 4 give 7 for rows 1–4; all other centres give 0.
- Saturation: step frame, 5×5 mode, SHIFT5=4 (MAG 720 → 45) → `pixel_out`=15.
- Random `in_ready` bubbles over two frames → output sequence identical to the continuous run; each output appears exactly 5 cycles after its triggering accept; `out_sof` pulses once per frame.
- Reset after 20 inputs, then a fresh frame → outputs match a clean-reset run. With `SOBEL_THRESH_EN` and `thresh`=5, the step frame gives 15 at cols 3 and 4, 0 elsewhere.

Source files
------------

// File: rtl/sobel_stream_filter_if.sv
// +--------------------------------------------------------------------+
// | sobel_stream_filter_if : pixel stream in/out bundle for the filter |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
`default_nettype none

interface sobel_stream_filter_if #(
  parameter int PIX_W = 4,
  parameter int OUT_W = 4
);
  logic [PIX_W-1:0] pixel_in;
  logic             in_ready;
  logic             mode_sel;
`ifdef SOBEL_THRESH_EN
  logic [OUT_W-1:0] thresh;
`endif
  logic [OUT_W-1:0] pixel_out;
  logic             out_ready;
  logic             out_sof;

`ifdef SOBEL_THRESH_EN
  modport master (
    output pixel_in, in_ready, mode_sel, thresh,
    input  pixel_out, out_ready, out_sof
  );
  modport slave (
    input  pixel_in, in_ready, mode_sel, thresh,
    output pixel_out, out_ready, out_sof
  );
`else
  modport master (
    output pixel_in, in_ready, mode_sel,
    input  pixel_out, out_ready, out_sof
  );
  modport slave (
    input  pixel_in, in_ready, mode_sel,
    output pixel_out, out_ready, out_sof
  );
`endif
endinterface

`default_nettype wire

// File: rtl/sobel_stream_filter.sv
// +--------------------------------------------------------------------+
// | sobel_stream_filter : streaming 3x3/5x5 Sobel |Gx|+|Gy| detector    |
// | Optional binarising threshold port: SOBEL_THRESH_EN                |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
`default_nettype none

module sobel_stream_filter #(
  parameter int PIX_W  = 4,
  parameter int OUT_W  = 4,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int SHIFT5 = 7,
  parameter int SHIFT3 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  sobel_stream_filter_if.slave  io
);

  localparam int COL_W   = $clog2(IMG_W);
  localparam int ROW_W   = $clog2(IMG_H);
  localparam int G_W     = PIX_W + 7;
  localparam int M_W     = PIX_W + 8;
  localparam int SAT_MAX = (1 << OUT_W) - 1;

  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_HI5   = COL_W'(IMG_W - 3);
  localparam logic [ROW_W-1:0] ROW_HI5   = ROW_W'(IMG_H - 3);
  localparam logic [COL_W-1:0] PRIME_COL = COL_W'(1);
  localparam logic [ROW_W-1:0] PRIME_ROW = ROW_W'(2);

  // 3x3 weights are the 5x5 taps padded with zeros so one datapath serves both
  localparam logic signed [3:0] S5W [5] = '{4'sd1, 4'sd4, 4'sd6, 4'sd4, 4'sd1};
  localparam logic signed [3:0] D5W [5] = '{-4'sd1, -4'sd2, 4'sd0, 4'sd2, 4'sd1};
  localparam logic signed [3:0] S3W [5] = '{4'sd0, 4'sd1, 4'sd2, 4'sd1, 4'sd0};
  localparam logic signed [3:0] D3W [5] = '{4'sd0, -4'sd1, 4'sd0, 4'sd1, 4'sd0};

  function automatic logic signed [G_W-1:0] ext(input logic [PIX_W-1:0] p);
    ext = $signed({{(G_W-PIX_W){1'b0}}, p});
  endfunction

  function automatic logic signed [G_W-1:0] wmul(input logic signed [G_W-1:0] x,
                                                 input logic signed [3:0]     k);
    case (k)
      4'sd1:   wmul = x;
      4'sd2:   wmul = x <<< 1;
      4'sd4:   wmul = x <<< 2;
      4'sd6:   wmul = (x <<< 2) + (x <<< 1);
      -4'sd1:  wmul = -x;
      -4'sd2:  wmul = -(x <<< 1);
      default: wmul = '0;
    endcase
  endfunction

  logic                     accept;
  logic                     emit;
  logic                     at_origin;
  logic                     cur_mode;
  logic                     cur_mask;

  logic [COL_W-1:0]         in_col_q, in_col_d;
  logic [ROW_W-1:0]         in_row_q, in_row_d;
  logic [COL_W-1:0]         c_col_q, c_col_d;
  logic [ROW_W-1:0]         c_row_q, c_row_d;
  logic                     primed_q, primed_d;
  logic                     mode_q, mode_d;

  logic [4:0][PIX_W-1:0]    col_tap;
  logic [4:0][4:0][PIX_W-1:0] win_q, win_d;

  // Per-stage side-band: index 0 travels with the window, index 4 feeds S5
  logic [4:0]               vld_q, vld_d;
  logic [4:0]               mode_p_q, mode_p_d;
  logic [4:0]               mask_q, mask_d;
  logic [4:0]               sof_q, sof_d;

  logic signed [G_W-1:0]    hs_q [5], hs_d [5];
  logic signed [G_W-1:0]    hd_q [5], hd_d [5];
  logic signed [G_W-1:0]    wx_q [5], wx_d [5];
  logic signed [G_W-1:0]    wy_q [5], wy_d [5];
  logic signed [G_W-1:0]    gx_q, gx_d;
  logic signed [G_W-1:0]    gy_q, gy_d;
  logic [M_W-1:0]           mag_q, mag_d;

  logic [G_W-1:0]           abs_x, abs_y;
  logic [M_W-1:0]           scaled;
  logic [OUT_W-1:0]         sat_val;
  logic [OUT_W-1:0]         edge_val;

  logic [OUT_W-1:0]         pixel_out_q, pixel_out_d;
  logic                     out_ready_q, out_ready_d;
  logic                     out_sof_q, out_sof_d;

  assign accept = io.in_ready;
  assign emit   = accept && primed_q;

  // Line buffers: buffer i holds the row accepted i+1 lines ago at each column
  for (genvar i = 0; i < 4; i++) begin : g_line_buf
    logic [PIX_W-1:0] mem [IMG_W];
    logic [PIX_W-1:0] rd;

    always_ff @(posedge clk) begin
      if (accept) begin
        mem[in_col_q] <= col_tap[i];
      end
    end

    assign rd = mem[in_col_q];
  end

  always_comb begin
    col_tap[0] = io.pixel_in;
    col_tap[1] = g_line_buf[0].rd;
    col_tap[2] = g_line_buf[1].rd;
    col_tap[3] = g_line_buf[2].rd;
    col_tap[4] = g_line_buf[3].rd;
  end

  always_comb begin
    in_col_d  = in_col_q;
    in_row_d  = in_row_q;
    c_col_d   = c_col_q;
    c_row_d   = c_row_q;
    primed_d  = primed_q;
    mode_d    = mode_q;
    win_d     = win_q;

    at_origin = (c_col_q == '0) && (c_row_q == '0);
    cur_mode  = at_origin ? io.mode_sel : mode_q;

    if (cur_mode) begin
      cur_mask = (c_col_q == '0) || (c_col_q == LAST_COL) ||
                 (c_row_q == '0) || (c_row_q == LAST_ROW);
    end else begin
      cur_mask = (c_col_q < COL_W'(2)) || (c_col_q > COL_HI5) ||
                 (c_row_q < ROW_W'(2)) || (c_row_q > ROW_HI5);
    end

    if (accept) begin
      if (in_col_q == LAST_COL) begin
        in_col_d = '0;
        in_row_d = (in_row_q == LAST_ROW) ? '0 : in_row_q + 1'b1;
      end else begin
        in_col_d = in_col_q + 1'b1;
      end

      // The (2*IMG_W+2)-th pixel since reset sits at row 2, column 1
      if ((in_row_q == PRIME_ROW) && (in_col_q == PRIME_COL)) begin
        primed_d = 1'b1;
      end

      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 4; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
        win_d[r][4] = col_tap[4-r];
      end
    end

    if (emit) begin
      mode_d = cur_mode;
      if (c_col_q == LAST_COL) begin
        c_col_d = '0;
        c_row_d = (c_row_q == LAST_ROW) ? '0 : c_row_q + 1'b1;
      end else begin
        c_col_d = c_col_q + 1'b1;
      end
    end
  end

  always_comb begin
    vld_d    = {vld_q[3:0], emit};
    mode_p_d = {mode_p_q[3:0], cur_mode};
    mask_d   = {mask_q[3:0], cur_mask};
    sof_d    = {sof_q[3:0], at_origin};
  end

  // S1: horizontal smoothing / derivative per window row
  always_comb begin
    for (int r = 0; r < 5; r++) begin
      hs_d[r] = '0;
      hd_d[r] = '0;
      for (int c = 0; c < 5; c++) begin
        hs_d[r] = hs_d[r] + wmul(ext(win_q[r][c]), mode_p_q[0] ? S3W[c] : S5W[c]);
        hd_d[r] = hd_d[r] + wmul(ext(win_q[r][c]), mode_p_q[0] ? D3W[c] : D5W[c]);
      end
    end
  end

  // S2: vertical weighting of each row term
  always_comb begin
    for (int r = 0; r < 5; r++) begin
      wx_d[r] = wmul(hd_q[r], mode_p_q[1] ? S3W[r] : S5W[r]);
      wy_d[r] = wmul(hs_q[r], mode_p_q[1] ? D3W[r] : D5W[r]);
    end
  end

  // S3 and S4: gradients, then |Gx|+|Gy|
  always_comb begin
    gx_d = '0;
    gy_d = '0;
    for (int r = 0; r < 5; r++) begin
      gx_d = gx_d + wx_q[r];
      gy_d = gy_d + wy_q[r];
    end
    abs_x = gx_q[G_W-1] ? $unsigned(-gx_q) : $unsigned(gx_q);
    abs_y = gy_q[G_W-1] ? $unsigned(-gy_q) : $unsigned(gy_q);
    mag_d = {1'b0, abs_x} + {1'b0, abs_y};
  end

  // S5: scale, saturate, optional threshold, border mask
  always_comb begin
    scaled  = mode_p_q[4] ? (mag_q >> SHIFT3) : (mag_q >> SHIFT5);
    sat_val = (scaled > M_W'(SAT_MAX)) ? '1 : OUT_W'(scaled);
`ifdef SOBEL_THRESH_EN
    edge_val = (sat_val >= io.thresh) ? '1 : '0;
`else
    edge_val = sat_val;
`endif
    out_ready_d = vld_q[4];
    out_sof_d   = vld_q[4] && sof_q[4];
    pixel_out_d = (vld_q[4] && !mask_q[4]) ? edge_val : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_col_q    <= '0;
      in_row_q    <= '0;
      c_col_q     <= '0;
      c_row_q     <= '0;
      primed_q    <= 1'b0;
      mode_q      <= 1'b0;
      win_q       <= '0;
      vld_q       <= '0;
      mode_p_q    <= '0;
      mask_q      <= '0;
      sof_q       <= '0;
      for (int r = 0; r < 5; r++) begin
        hs_q[r] <= '0;
        hd_q[r] <= '0;
        wx_q[r] <= '0;
        wy_q[r] <= '0;
      end
      gx_q        <= '0;
      gy_q        <= '0;
      mag_q       <= '0;
      pixel_out_q <= '0;
      out_ready_q <= 1'b0;
      out_sof_q   <= 1'b0;
    end else begin
      in_col_q    <= in_col_d;
      in_row_q    <= in_row_d;
      c_col_q     <= c_col_d;
      c_row_q     <= c_row_d;
      primed_q    <= primed_d;
      mode_q      <= mode_d;
      win_q       <= win_d;
      vld_q       <= vld_d;
      mode_p_q    <= mode_p_d;
      mask_q      <= mask_d;
      sof_q       <= sof_d;
      hs_q        <= hs_d;
      hd_q        <= hd_d;
      wx_q        <= wx_d;
      wy_q        <= wy_d;
      gx_q        <= gx_d;
      gy_q        <= gy_d;
      mag_q       <= mag_d;
      pixel_out_q <= pixel_out_d;
      out_ready_q <= out_ready_d;
      out_sof_q   <= out_sof_d;
    end
  end

  assign io.pixel_out = pixel_out_q;
  assign io.out_ready = out_ready_q;
  assign io.out_sof   = out_sof_q;

endmodule

`default_nettype wire

// File: tb/tb_sobel_stream_filter.sv
// +--------------------------------------------------------------------+
// | tb_sobel_stream_filter : directed bench for sobel_stream_filter    |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_sobel_stream_filter;

  localparam int IMG_W  = 8;
  localparam int IMG_H  = 6;
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int PRIME  = 2 * IMG_W + 2;
  localparam int K_FLAT = 0;
  localparam int K_STEP = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  int   compared   = 0;
  int   mismatched = 0;

  int   acc_cyc [$];
  int   out_cyc [$];
  int   out_a   [$];
  int   out_b   [$];
  int   out_s   [$];
  int   fkind   [$];
  bit   fmode   [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sobel_stream_filter_if #(.PIX_W(4), .OUT_W(4)) io_a ();
  sobel_stream_filter_if #(.PIX_W(4), .OUT_W(4)) io_b ();

  assign io_b.pixel_in = io_a.pixel_in;
  assign io_b.in_ready = io_a.in_ready;
  assign io_b.mode_sel = io_a.mode_sel;
`ifdef SOBEL_THRESH_EN
  assign io_b.thresh   = io_a.thresh;
`endif

  sobel_stream_filter #(
    .PIX_W(4), .OUT_W(4), .IMG_W(IMG_W), .IMG_H(IMG_H), .SHIFT5(7), .SHIFT3(3)
  ) u_dut_a (
    .clk (clk),
    .rst (rst),
    .io  (io_a)
  );

  // Second instance with a small 5x5 shift to exercise saturation
  sobel_stream_filter #(
    .PIX_W(4), .OUT_W(4), .IMG_W(IMG_W), .IMG_H(IMG_H), .SHIFT5(4), .SHIFT3(3)
  ) u_dut_b (
    .clk (clk),
    .rst (rst),
    .io  (io_b)
  );

  always @(negedge clk) begin
    if (!rst && io_a.out_ready) begin
      out_a.push_back(int'(io_a.pixel_out));
      out_b.push_back(int'(io_b.pixel_out));
      out_s.push_back(int'(io_a.out_sof));
      out_cyc.push_back(cyc);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Hand-derived results for the step frame (cols 0-3 = 0, cols 4-7 = 15)
  function automatic int exp_val(input int kind, input bit mode, input bit sat,
                                 input int r, input int c);
    int v;
    v = 0;
    if (kind == K_STEP) begin
      if (!mode) begin
        if (r >= 2 && r <= 3) begin
          if (c == 2 || c == 5) v = sat ? 15 : 1;
          else if (c == 3 || c == 4) v = sat ? 15 : 5;
        end
      end else if (r >= 1 && r <= 4 && (c == 3 || c == 4)) begin
        v = 7;
      end
    end
`ifdef SOBEL_THRESH_EN
    v = (v >= 5) ? 15 : 0;
`endif
    return v;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic put(input logic [3:0] p, input logic m);
    @(negedge clk);
    io_a.pixel_in = p;
    io_a.mode_sel = m;
    io_a.in_ready = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc.push_back(cyc);
    io_a.in_ready = 1'b0;
  endtask

  task automatic feed_frame(input int kind, input bit mode, input bit bub,
                            input int toggle_at);
    fkind.push_back(kind);
    fmode.push_back(mode);
    for (int i = 0; i < NPIX; i++) begin
      logic [3:0] p;
      bit         m;
      if (bub) idle($urandom_range(0, 2));
      p = (kind == K_FLAT) ? 4'd7 : (((i % IMG_W) >= 4) ? 4'd15 : 4'd0);
      m = (toggle_at >= 0 && i >= toggle_at) ? ~mode : mode;
      put(p, m);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    io_a.in_ready = 1'b0;
    io_a.pixel_in = 4'd0;
    io_a.mode_sel = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_pixel_out", int'(io_a.pixel_out), 0);
    check("rst_out_ready", int'(io_a.out_ready), 0);
    check("rst_out_sof",   int'(io_a.out_sof),   0);
    acc_cyc.delete();
    out_cyc.delete();
    out_a.delete();
    out_b.delete();
    out_s.delete();
    fkind.delete();
    fmode.delete();
    rst = 1'b0;
  endtask

  task automatic check_stream(input int n_exp);
    int n;
    check("out_count", out_a.size(), n_exp);
    n = (out_a.size() < n_exp) ? out_a.size() : n_exp;
    for (int k = 0; k < n; k++) begin
      int f, pos, r, c;
      f   = k / NPIX;
      pos = k % NPIX;
      r   = pos / IMG_W;
      c   = pos % IMG_W;
      check($sformatf("val_a f%0d r%0d c%0d", f, r, c), out_a[k],
            exp_val(fkind[f], fmode[f], 1'b0, r, c));
      check($sformatf("val_sat f%0d r%0d c%0d", f, r, c), out_b[k],
            exp_val(fkind[f], fmode[f], 1'b1, r, c));
      check($sformatf("sof f%0d r%0d c%0d", f, r, c), out_s[k], (pos == 0) ? 1 : 0);
      check($sformatf("latency f%0d r%0d c%0d", f, r, c),
            out_cyc[k] - acc_cyc[k + PRIME], 5);
    end
  endtask

  initial begin
    io_a.pixel_in = 4'd0;
    io_a.in_ready = 1'b0;
    io_a.mode_sel = 1'b0;
`ifdef SOBEL_THRESH_EN
    io_a.thresh   = 4'd5;
`endif

    // Flat, step 5x5, step 3x3 with a mid-frame mode flip, then two bubbly step frames
    do_reset();
    feed_frame(K_FLAT, 1'b0, 1'b0, -1);
    feed_frame(K_STEP, 1'b0, 1'b0, -1);
    feed_frame(K_STEP, 1'b1, 1'b0, 30);
    feed_frame(K_STEP, 1'b0, 1'b1, -1);
    feed_frame(K_STEP, 1'b0, 1'b1, -1);
    idle(10);
    check_stream(5 * NPIX - PRIME);

    // Reset with two outputs in flight, then a fresh run
    do_reset();
    for (int i = 0; i < 20; i++) begin
      put(((i % IMG_W) >= 4) ? 4'd15 : 4'd0, 1'b0);
    end
    do_reset();
    idle(10);
    check("post_reset_silent", out_a.size(), 0);
    feed_frame(K_STEP, 1'b0, 1'b0, -1);
    feed_frame(K_STEP, 1'b1, 1'b0, -1);
    idle(10);
    check_stream(2 * NPIX - PRIME);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
